// File: rtl/vr_pkg.sv
// -----------------------------------------------------------------------------
// vr_pkg
// Shared constants and beat type for the valid/ready elastic buffer.
//   VR_ADDR_W / VR_DATA_W / VR_DEPTH : default field widths and entry count
//   vr_beat_t                        : packed {addr, data} at default widths
// -----------------------------------------------------------------------------
package vr_pkg;

    localparam int VR_ADDR_W = 2;
    localparam int VR_DATA_W = 4;
    localparam int VR_DEPTH  = 4;

    typedef struct packed {
        logic [VR_ADDR_W-1:0] addr;
        logic [VR_DATA_W-1:0] data;
    } vr_beat_t;

endpackage

// File: rtl/vr_stability_checker.sv
// -----------------------------------------------------------------------------
// vr_stability_checker
// Watches a valid/ready producer interface. Once a beat has been offered and
// stalled (valid && !ready), the producer must keep valid high and hold addr
// and data unchanged on the following cycle. Any breach sets a sticky error
// that only reset clears. Only instantiated when VR_STABILITY_CHECK_EN is
// defined.
// Ports:
//   clk, rst     : clock, synchronous active-low reset
//   valid, ready : producer handshake being observed
//   addr, data   : producer payload being observed
//   err          : sticky protocol-violation flag (registered)
// -----------------------------------------------------------------------------
module vr_stability_checker
    import vr_pkg::*;
#(
    parameter int ADDR_W = VR_ADDR_W,
    parameter int DATA_W = VR_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid,
    input  logic              ready,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data,
    output logic              err
);

    logic              stall_r;
    logic [ADDR_W-1:0] addr_r;
    logic [DATA_W-1:0] data_r;
    logic              err_r;
    logic              violation_s;

    // Violation: previous cycle stalled, and this cycle the beat was dropped or altered.
    always_comb begin
        violation_s = 1'b0;
        if (stall_r) begin
            violation_s = !valid || (addr != addr_r) || (data != data_r);
        end else begin
            violation_s = 1'b0;
        end
    end

    // Remember last cycle's stall state and payload; accumulate the sticky error.
    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_r <= 1'b0;
            addr_r  <= '0;
            data_r  <= '0;
            err_r   <= 1'b0;
        end else begin
            stall_r <= valid && !ready;
            addr_r  <= addr;
            data_r  <= data;
            if (violation_s) begin
                err_r <= 1'b1;
            end
        end
    end

    assign err = err_r;

    // Report every individual violation as it happens.
    stable_while_stalled_a: assert property (@(posedge clk) disable iff (!rst) !violation_s)
        else $error("vr_stability_checker: producer beat dropped or changed while stalled");

endmodule

// File: rtl/vr_elastic_buffer.sv
// -----------------------------------------------------------------------------
// vr_elastic_buffer
// DEPTH-entry circular valid/ready buffer for address/data beats. Full/empty
// come from a registered occupancy count (never from pointer compare), so
// s_ready has no combinational path from m_ready, and a write into an empty
// buffer appears on m_* one cycle later (no fall-through).
// Optional feature: define VR_STABILITY_CHECK_EN to elaborate the producer
// stability checker driving proto_err; otherwise proto_err is tied low.
// Ports:
//   clk, rst                   : clock, synchronous active-low reset
//   s_valid/s_ready/s_addr/s_data : producer side
//   m_valid/m_ready/m_addr/m_data : consumer side (head entry)
//   count                      : current occupancy
//   proto_err                  : sticky producer-protocol violation
// -----------------------------------------------------------------------------
module vr_elastic_buffer
    import vr_pkg::*;
#(
    parameter int ADDR_W = VR_ADDR_W,
    parameter int DATA_W = VR_DATA_W,
    parameter int DEPTH  = VR_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       s_valid,
    output logic                       s_ready,
    input  logic [ADDR_W-1:0]          s_addr,
    input  logic [DATA_W-1:0]          s_data,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [ADDR_W-1:0]          m_addr,
    output logic [DATA_W-1:0]          m_data,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       proto_err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [ADDR_W-1:0] addr_mem_r [DEPTH];
    logic [DATA_W-1:0] data_mem_r [DEPTH];

    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [CNT_W-1:0]  count_r;
    logic              s_ready_r;
    logic              m_valid_r;
    logic [ADDR_W-1:0] m_addr_r;
    logic [DATA_W-1:0] m_data_r;

    logic              wr_en_s;
    logic              rd_en_s;
    logic [PTR_W-1:0]  wr_ptr_next_s;
    logic [PTR_W-1:0]  rd_ptr_next_s;
    logic [CNT_W-1:0]  count_next_s;
    logic [ADDR_W-1:0] head_addr_next_s;
    logic [DATA_W-1:0] head_data_next_s;
    logic              proto_err_s;

    assign wr_en_s = s_valid && s_ready_r;
    assign rd_en_s = m_valid_r && m_ready;

    // Next pointers, occupancy and head entry.
    always_comb begin
        wr_ptr_next_s    = wr_ptr_r;
        rd_ptr_next_s    = rd_ptr_r;
        count_next_s     = count_r;
        head_addr_next_s = addr_mem_r[rd_ptr_r];
        head_data_next_s = data_mem_r[rd_ptr_r];

        if (wr_en_s) begin
            wr_ptr_next_s = wr_ptr_r + PTR_W'(1);
        end else begin
            wr_ptr_next_s = wr_ptr_r;
        end

        if (rd_en_s) begin
            rd_ptr_next_s = rd_ptr_r + PTR_W'(1);
        end else begin
            rd_ptr_next_s = rd_ptr_r;
        end

        case ({wr_en_s, rd_en_s})
            2'b10:   count_next_s = count_r + CNT_W'(1);
            2'b01:   count_next_s = count_r - CNT_W'(1);
            default: count_next_s = count_r;
        endcase

        // The head register mirrors store[rd_ptr]; if this cycle's write lands
        // on the slot that becomes the head, take the incoming beat directly.
        if (wr_en_s && (wr_ptr_r == rd_ptr_next_s)) begin
            head_addr_next_s = s_addr;
            head_data_next_s = s_data;
        end else begin
            head_addr_next_s = addr_mem_r[rd_ptr_next_s];
            head_data_next_s = data_mem_r[rd_ptr_next_s];
        end
    end

    // Beat store; contents deliberately not cleared by reset.
    always_ff @(posedge clk) begin
        if (rst && wr_en_s) begin
            addr_mem_r[wr_ptr_r] <= s_addr;
            data_mem_r[wr_ptr_r] <= s_data;
        end
    end

    // Pointers, occupancy and registered handshake/head outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_r  <= '0;
            rd_ptr_r  <= '0;
            count_r   <= '0;
            s_ready_r <= 1'b1;
            m_valid_r <= 1'b0;
            m_addr_r  <= '0;
            m_data_r  <= '0;
        end else begin
            wr_ptr_r  <= wr_ptr_next_s;
            rd_ptr_r  <= rd_ptr_next_s;
            count_r   <= count_next_s;
            s_ready_r <= (count_next_s != CNT_W'(DEPTH));
            m_valid_r <= (count_next_s != CNT_W'(0));
            m_addr_r  <= head_addr_next_s;
            m_data_r  <= head_data_next_s;
        end
    end

`ifdef VR_STABILITY_CHECK_EN
    vr_stability_checker #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_stability_checker (
        .clk   (clk),
        .rst   (rst),
        .valid (s_valid),
        .ready (s_ready_r),
        .addr  (s_addr),
        .data  (s_data),
        .err   (proto_err_s)
    );
`else
    assign proto_err_s = 1'b0;
`endif

    assign s_ready   = s_ready_r;
    assign m_valid   = m_valid_r;
    assign m_addr    = m_addr_r;
    assign m_data    = m_data_r;
    assign count     = count_r;
    assign proto_err = proto_err_s;

endmodule

// File: tb/tb_vr_elastic_buffer.sv
module tb_vr_elastic_buffer;
    import vr_pkg::*;

`ifdef VR_STABILITY_CHECK_EN
    localparam int EXP_ERR = 1;
`else
    localparam int EXP_ERR = 0;
`endif

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 s_valid;
    logic                 s_ready;
    logic [VR_ADDR_W-1:0] s_addr;
    logic [VR_DATA_W-1:0] s_data;
    logic                 m_valid;
    logic                 m_ready;
    logic [VR_ADDR_W-1:0] m_addr;
    logic [VR_DATA_W-1:0] m_data;
    logic [2:0]           count;
    logic                 proto_err;

    int       n_checks = 0;
    int       n_fail   = 0;
    int       cyc      = 0;
    bit       streaming = 1'b0;
    vr_beat_t exp_q[$];

    vr_elastic_buffer #(
        .ADDR_W (VR_ADDR_W),
        .DATA_W (VR_DATA_W),
        .DEPTH  (VR_DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_addr    (s_addr),
        .s_data    (s_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_addr    (m_addr),
        .m_data    (m_data),
        .count     (count),
        .proto_err (proto_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every consumer transfer is checked against the scoreboard.
    always @(negedge clk) begin
        vr_beat_t e;
        if (rst && m_valid && m_ready) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_beat: got addr=%0d data=%0d, required no beat", m_addr, m_data);
            end else begin
                e = exp_q.pop_front();
                if (m_addr !== e.addr || m_data !== e.data) begin
                    n_fail++;
                    $display("FAIL beat_order: got addr=%0d data=%0d, required addr=%0d data=%0d",
                             m_addr, m_data, e.addr, e.data);
                end
            end
        end
        if (streaming) begin
            n_checks++;
            if (count > 3'd1) begin
                n_fail++;
                $display("FAIL stream_count: got %0d, required <= 1", count);
            end
        end
    end

    task automatic check(input string name, input int actual, input int required);
        n_checks++;
        if (actual !== required) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, actual, required);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer a beat and hold it until accepted; push the expected beat on acceptance.
    task automatic send(input logic [VR_ADDR_W-1:0] a, input logic [VR_DATA_W-1:0] d);
        int       waited;
        vr_beat_t b;
        s_addr  = a;
        s_data  = d;
        s_valid = 1'b1;
        waited  = 0;
        @(negedge clk);
        while (!s_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!s_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: got s_ready=0 for 50 cycles, required acceptance");
        end else begin
            b.addr = a;
            b.data = d;
            exp_q.push_back(b);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int w;
        w = 0;
        while ((exp_q.size() != 0 || m_valid) && w < 40) begin
            tick();
            w++;
        end
        n_checks++;
        if (exp_q.size() != 0 || m_valid) begin
            n_fail++;
            $display("FAIL drain_timeout: got %0d beats outstanding, required 0", exp_q.size());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c0;
        rst     = 1'b0;
        s_valid = 1'b0;
        s_addr  = 2'd0;
        s_data  = 4'd0;
        m_ready = 1'b0;

        // Reset then idle
        tick();
        tick();
        check("rst_s_ready",   int'(s_ready),   1);
        check("rst_m_valid",   int'(m_valid),   0);
        check("rst_count",     int'(count),     0);
        check("rst_proto_err", int'(proto_err), 0);
        check("rst_m_addr",    int'(m_addr),    0);
        check("rst_m_data",    int'(m_data),    0);
        rst = 1'b1;
        tick();

        // Single beat
        m_ready = 1'b1;
        send(2'd1, 4'd1);
        s_valid = 1'b0;
        check("single_m_valid", int'(m_valid), 1);
        check("single_m_addr",  int'(m_addr),  1);
        check("single_m_data",  int'(m_data),  1);
        check("single_count",   int'(count),   1);
        tick();
        check("single_m_valid_after", int'(m_valid), 0);
        check("single_count_after",   int'(count),   0);

        // Fill and backpressure
        m_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(2'(i), 4'(i));
        s_addr  = 2'd0;
        s_data  = 4'd4;
        check("full_s_ready", int'(s_ready), 0);
        check("full_count",   int'(count),   4);
        tick();
        tick();
        check("held_count",   int'(count),   4);
        check("held_s_ready", int'(s_ready), 0);
        m_ready = 1'b1;
        tick();
        check("s_ready_after_first_read", int'(s_ready), 1);
        check("count_after_first_read",   int'(count),   3);
        send(2'd0, 4'd4);
        send(2'd1, 4'd5);
        s_valid = 1'b0;
        drain();
        check("fill_count_drained", int'(count), 0);

        // Streaming wrap: 20 back-to-back beats
        streaming = 1'b1;
        c0 = cyc;
        for (int i = 0; i < 20; i++) send(2'((i + 1) % 4), 4'((i * 5 + 3) % 16));
        check("stream_cycles", cyc - c0, 20);
        s_valid = 1'b0;
        drain();
        streaming = 1'b0;
        // Head now shows the stale slot-3 entry, last written by stream beat 16
        check("stale_m_addr", int'(m_addr), 1);
        check("stale_m_data", int'(m_data), 3);

        // Stability violation while full
        m_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(2'(i), 4'(8 + i));
        s_addr  = 2'd2;
        s_data  = 4'd0;
        tick();
        check("stall_proto_err_before", int'(proto_err), 0);
        s_data = 4'd1;
        tick();
        check("stall_proto_err", int'(proto_err), EXP_ERR);
        tick();
        check("stall_proto_err_sticky", int'(proto_err), EXP_ERR);
        m_ready = 1'b1;
        send(2'd2, 4'd1);
        s_valid = 1'b0;
        drain();
        check("stall_proto_err_end", int'(proto_err), EXP_ERR);

        // Reset mid-stream
        m_ready = 1'b0;
        for (int i = 0; i < 3; i++) send(2'd3, 4'(12 + i));
        s_valid = 1'b0;
        check("pre_reset_count", int'(count), 3);
        rst = 1'b0;
        tick();
        exp_q.delete();
        check("midrst_count",     int'(count),     0);
        check("midrst_m_valid",   int'(m_valid),   0);
        check("midrst_s_ready",   int'(s_ready),   1);
        check("midrst_proto_err", int'(proto_err), 0);
        rst = 1'b1;
        m_ready = 1'b1;
        repeat (5) tick();
        check("post_reset_m_valid", int'(m_valid), 0);
        send(2'd1, 4'd9);
        s_valid = 1'b0;
        drain();
        check("final_count", int'(count), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
